endgame_ctrl: RTL and testbench
===============================

// Module: endgame_ctrl
// PURPOSE
//  Sequences the "END" game-over overlay for the 640x480 pong display. On a game-over event it
//  freezes play, slides the text down from the top, blinks it, then holds it steady until the
//  player restarts. It drives start_x/start_y and a visibility gate into the endgame text
//  renderer, and issues a one-cycle restart request to the game core.
// PARAMETERS
//  H_ACTIVE     640  visible width, pixels
//  TEXT_W       93   rendered text width (3 chars at a 31-px pitch)
//  Y_START      0    start_y at the start of the slide
//  Y_TARGET     200  final start_y
//  SLIDE_STEP   8    pixels moved per frame_tick while sliding
//  BLINK_PERIOD 15   frames per visibility toggle
//  BLINK_TOGGLES 6   toggles before steady display (even -> ends visible)
//  MIN_HOLD     60   frames in SHOW before restart is accepted
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous reset, active low
//  frame_tick    in   1   one-cycle pulse per frame (start of vblank)
//  game_over     in   1   one-cycle pulse from the score logic
//  winner_in     in   1   winning player (0 = left, 1 = right), valid with game_over
//  restart_btn   in   1   debounced restart button, level
//  start_x       out  10  text origin x
//  start_y       out  10  text origin y
//  text_en       out  1   gate: renderer output is ANDed with this
//  freeze        out  1   holds ball and paddles while high
//  winner        out  1   latched winner
//  restart_req   out  1   one-cycle restart pulse
// BEHAVIOUR
//  Interface: one clock, clk; reset rst_n is synchronous and active low.
//  All outputs are registered.
//  Reset values: state=IDLE, start_y=Y_START, start_x=(H_ACTIVE-TEXT_W)/2 (=273, constant),
//    text_en=0, freeze=0, winner=0, restart_req=0, all counters 0.
//  A reset at any point, including mid-sequence, returns the block to IDLE on the next edge.
//  FSM: IDLE -> SLIDE -> BLINK -> SHOW -> IDLE.
//  IDLE:
//   - text_en=0, freeze=0.
//   - game_over=1: latch winner_in, set start_y=Y_START, go to SLIDE on the next edge.
//   - freeze and text_en rise in that same edge.
//  SLIDE:
//   - text_en=1, freeze=1.
//   - Each frame_tick: sum=start_y+SLIDE_STEP, computed at 11 bits.
//   - If sum>=Y_TARGET: start_y=Y_TARGET, go to BLINK. Otherwise start_y=sum.
//   - No overshoot and no wrap past 1023.
//  BLINK:
//   - freeze=1.
//   - frame counter counts frame_ticks. At BLINK_PERIOD: counter=0, text_en toggles,
//     toggle_cnt increments.
//   - When toggle_cnt reaches BLINK_TOGGLES: go to SHOW with text_en=1.
//  SHOW:
//   - text_en=1, freeze=1.
//   - hold_cnt increments on frame_tick and saturates at MIN_HOLD.
//   - A restart_btn rising edge (previous-cycle sample 0, current 1) with hold_cnt==MIN_HOLD:
//     restart_req=1 for one cycle, go to IDLE. text_en and freeze drop in the same edge.
//  Ignored events:
//   - game_over outside IDLE.
//   - restart_btn outside SHOW, or before hold is satisfied.
//   - A button held down through the transition into SHOW does not count as an edge.
//  Simultaneous events:
//   - restart edge and frame_tick in the same cycle in SHOW: restart wins.
//   - game_over and frame_tick in the same cycle in IDLE: enter SLIDE, no slide step.
//  Latency: game_over -> text_en=1 in 1 cycle; restart edge -> restart_req in 1 cycle.
//  Counters are cleared on every state entry. winner holds until the next game_over or reset.
// TESTING
//  1. Reset, then game_over with winner_in=1
//     -> next cycle: SLIDE, freeze=1, text_en=1, winner=1, start_y=0, start_x=273.
//  2. 25 frame_ticks in SLIDE (step 8, target 200)
//     -> start_y=8,16,...,200; enters BLINK exactly at the tick reaching 200.
//  3. Y_TARGET=197 override -> start_y clamps to 197 on tick 25, never 200.
//  4. BLINK
//     -> text_en toggles every 15 ticks, 6 toggles;
//     -> SHOW after 90 ticks with text_en=1.
//  5. restart pressed at SHOW hold=30 -> ignored.
//     Released and pressed again at hold=60 -> restart_req for 1 cycle, IDLE, freeze=0.
//  6. rst_n=0 for 1 cycle mid-BLINK -> IDLE, all outputs at reset values;
//     a game_over in the reset cycle is ignored.

Source files
------------

// File: rtl/endgame_ctrl.sv
// Game-over overlay sequencer: freezes play, slides the "END" text down, blinks it,
// then holds it steady until a qualified restart button edge requests a new game.
module endgame_ctrl #(
    parameter int H_ACTIVE      = 640,
    parameter int TEXT_W        = 93,
    parameter int Y_START       = 0,
    parameter int Y_TARGET      = 200,
    parameter int SLIDE_STEP    = 8,
    parameter int BLINK_PERIOD  = 15,
    parameter int BLINK_TOGGLES = 6,
    parameter int MIN_HOLD      = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       winner_in,
    input  logic       restart_btn,
    output logic [9:0] start_x,
    output logic [9:0] start_y,
    output logic       text_en,
    output logic       freeze,
    output logic       winner,
    output logic       restart_req
);

    localparam int FW = $clog2(BLINK_PERIOD + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam int HW = $clog2(MIN_HOLD + 1);

    localparam logic [9:0]  START_X   = 10'((H_ACTIVE - TEXT_W) / 2);
    localparam logic [9:0]  Y_START_V = 10'(Y_START);
    localparam logic [9:0]  Y_TGT_V   = 10'(Y_TARGET);
    localparam logic [10:0] Y_TGT_11  = 11'(Y_TARGET);
    localparam logic [10:0] STEP_11   = 11'(SLIDE_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLIDE,
        S_BLINK,
        S_SHOW
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      start_x_q;
    logic [9:0]      start_y_q, start_y_d;
    logic            text_en_q, text_en_d;
    logic            freeze_q, freeze_d;
    logic            winner_q, winner_d;
    logic            restart_q, restart_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TW-1:0]   tog_cnt_q, tog_cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            btn_prev_q;

    logic [10:0]     slide_sum;
    logic [TW-1:0]   tog_inc;
    logic            btn_rise;

    always_comb begin
        state_d     = state_q;
        start_y_d   = start_y_q;
        text_en_d   = text_en_q;
        freeze_d    = freeze_q;
        winner_d    = winner_q;
        restart_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        hold_d      = hold_q;

        // 11-bit sum so a step past 1023 is seen as >= target instead of wrapping
        slide_sum = {1'b0, start_y_q} + STEP_11;
        tog_inc   = tog_cnt_q + TW'(1);
        btn_rise  = restart_btn & ~btn_prev_q;

        case (state_q)
            S_IDLE: begin
                text_en_d = 1'b0;
                freeze_d  = 1'b0;
                if (game_over) begin
                    state_d     = S_SLIDE;
                    winner_d    = winner_in;
                    start_y_d   = Y_START_V;
                    text_en_d   = 1'b1;
                    freeze_d    = 1'b1;
                    frame_cnt_d = '0;
                    tog_cnt_d   = '0;
                    hold_d      = '0;
                end
            end
            S_SLIDE: begin
                text_en_d = 1'b1;
                freeze_d  = 1'b1;
                if (frame_tick) begin
                    if (slide_sum >= Y_TGT_11) begin
                        start_y_d   = Y_TGT_V;
                        state_d     = S_BLINK;
                        frame_cnt_d = '0;
                        tog_cnt_d   = '0;
                        hold_d      = '0;
                    end else begin
                        start_y_d = slide_sum[9:0];
                    end
                end
            end
            S_BLINK: begin
                freeze_d = 1'b1;
                if (frame_tick) begin
                    if (frame_cnt_q == FW'(BLINK_PERIOD - 1)) begin
                        frame_cnt_d = '0;
                        text_en_d   = ~text_en_q;
                        tog_cnt_d   = tog_inc;
                        if (tog_inc == TW'(BLINK_TOGGLES)) begin
                            state_d   = S_SHOW;
                            text_en_d = 1'b1;
                            tog_cnt_d = '0;
                            hold_d    = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            S_SHOW: begin
                text_en_d = 1'b1;
                freeze_d  = 1'b1;
                // A restart edge beats a coincident frame_tick
                if (btn_rise && (hold_q == HW'(MIN_HOLD))) begin
                    restart_d   = 1'b1;
                    state_d     = S_IDLE;
                    text_en_d   = 1'b0;
                    freeze_d    = 1'b0;
                    frame_cnt_d = '0;
                    tog_cnt_d   = '0;
                    hold_d      = '0;
                end else if (frame_tick && (hold_q != HW'(MIN_HOLD))) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        start_x_q <= START_X;
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_y_q   <= Y_START_V;
            text_en_q   <= 1'b0;
            freeze_q    <= 1'b0;
            winner_q    <= 1'b0;
            restart_q   <= 1'b0;
            frame_cnt_q <= '0;
            tog_cnt_q   <= '0;
            hold_q      <= '0;
            btn_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_y_q   <= start_y_d;
            text_en_q   <= text_en_d;
            freeze_q    <= freeze_d;
            winner_q    <= winner_d;
            restart_q   <= restart_d;
            frame_cnt_q <= frame_cnt_d;
            tog_cnt_q   <= tog_cnt_d;
            hold_q      <= hold_d;
            btn_prev_q  <= restart_btn;
        end
    end

    assign start_x     = start_x_q;
    assign start_y     = start_y_q;
    assign text_en     = text_en_q;
    assign freeze      = freeze_q;
    assign winner      = winner_q;
    assign restart_req = restart_q;

endmodule

// File: tb/tb_endgame_ctrl.sv
// Bench for endgame_ctrl: scripted vector table, corner-case sequences, and a
// randomized run scored against a phase/tick-count reference model.
module tb_endgame_ctrl;

    localparam int TGT      = 200;
    localparam int TGT2     = 197;
    localparam int STEP     = 8;
    localparam int PERIOD   = 15;
    localparam int TOGGLES  = 6;
    localparam int HOLD     = 60;
    localparam int XPOS     = 273;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_over = 1'b0;
    logic       winner_in = 1'b0;
    logic       restart_btn = 1'b0;
    logic [9:0] start_x, start_y;
    logic       text_en, freeze, winner, restart_req;
    logic [9:0] start_x2, start_y2;
    logic       text_en2, freeze2, winner2, restart_req2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    endgame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_over(game_over),
        .winner_in(winner_in), .restart_btn(restart_btn),
        .start_x(start_x), .start_y(start_y), .text_en(text_en), .freeze(freeze),
        .winner(winner), .restart_req(restart_req)
    );

    endgame_ctrl #(.Y_TARGET(TGT2)) dut197 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_over(game_over),
        .winner_in(winner_in), .restart_btn(restart_btn),
        .start_x(start_x2), .start_y(start_y2), .text_en(text_en2), .freeze(freeze2),
        .winner(winner2), .restart_req(restart_req2)
    );

    // Reference model: phase 0 idle, 1 slide, 2 blink, 3 show
    int m_phase = 0, m_y = 0, m_bt = 0, m_hold = 0;
    bit m_w = 0, m_req = 0, m_prev = 0;

    function automatic void model_step(bit rn, bit fr, bit go, bit win, bit btn);
        m_req = 0;
        if (!rn) begin
            m_phase = 0; m_y = 0; m_bt = 0; m_hold = 0; m_w = 0; m_prev = 0;
        end else begin
            case (m_phase)
                0: if (go) begin m_phase = 1; m_y = 0; m_w = win; end
                1: if (fr) begin
                    m_y = (m_y + STEP >= TGT) ? TGT : m_y + STEP;
                    if (m_y == TGT) begin m_phase = 2; m_bt = 0; end
                end
                2: if (fr) begin
                    m_bt++;
                    if (m_bt == PERIOD * TOGGLES) begin m_phase = 3; m_hold = 0; end
                end
                default: begin
                    if (btn && !m_prev && m_hold == HOLD) begin
                        m_phase = 0; m_req = 1;
                    end else if (fr && m_hold < HOLD) begin
                        m_hold++;
                    end
                end
            endcase
            m_prev = btn;
        end
    endfunction

    function automatic bit model_ten();
        case (m_phase)
            0: return 1'b0;
            2: return ((m_bt / PERIOD) % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(bit rn, bit fr, bit go, bit win, bit btn);
        rst_n = rn; frame_tick = fr; game_over = go; winner_in = win; restart_btn = btn;
        @(posedge clk);
        model_step(rn, fr, go, win, btn);
        #1;
    endtask

    task automatic expect_all(string nm, int y, bit ten, bit frz, bit w, bit req);
        chk({nm, " start_y"}, int'(start_y), y);
        chk({nm, " text_en"}, int'(text_en), int'(ten));
        chk({nm, " freeze"}, int'(freeze), int'(frz));
        chk({nm, " winner"}, int'(winner), int'(w));
        chk({nm, " restart_req"}, int'(restart_req), int'(req));
    endtask

    typedef struct {
        bit rn, fr, go, win, btn;
        int y, y2;
        bit ten, frz, w, req;
    } vec_t;

    vec_t tbl[$];

    function automatic void push(bit rn, bit fr, bit go, bit win, bit btn,
                                 int y, int y2, bit ten, bit frz, bit w, bit req);
        vec_t v;
        v.rn = rn; v.fr = fr; v.go = go; v.win = win; v.btn = btn;
        v.y = y; v.y2 = y2; v.ten = ten; v.frz = frz; v.w = w; v.req = req;
        tbl.push_back(v);
    endfunction

    initial begin
        bit btn_r;
        bit rn_r;

        // Reset, game_over, 25-tick slide, 90-tick blink ending in SHOW
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0);
        for (int k = 1; k <= 25; k++)
            push(1, 1, 0, 0, 0, STEP * k, (STEP * k > TGT2) ? TGT2 : STEP * k, 1, 1, 1, 0);
        for (int k = 1; k <= PERIOD * TOGGLES; k++)
            push(1, 1, 0, 0, 0, TGT, TGT2, ((k / PERIOD) % 2) == 0, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].fr, tbl[i].go, tbl[i].win, tbl[i].btn);
            expect_all($sformatf("vec%0d", i), tbl[i].y, tbl[i].ten, tbl[i].frz, tbl[i].w, tbl[i].req);
            chk($sformatf("vec%0d start_x", i), int'(start_x), XPOS);
            chk($sformatf("vec%0d y_t197", i), int'(start_y2), tbl[i].y2);
        end

        // SHOW: early press ignored, held button is not an edge, fresh press restarts
        for (int k = 0; k < 30; k++) drive(1, 1, 0, 0, 0);
        expect_all("show_hold30", TGT, 1, 1, 1, 0);
        drive(1, 0, 0, 0, 1);
        expect_all("early_press", TGT, 1, 1, 1, 0);
        for (int k = 0; k < 30; k++) drive(1, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        expect_all("held_at_hold60", TGT, 1, 1, 1, 0);
        drive(1, 0, 0, 0, 0);
        expect_all("release", TGT, 1, 1, 1, 0);
        drive(1, 0, 0, 0, 1);
        expect_all("restart_press", TGT, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1);
        expect_all("restart_pulse_end", TGT, 0, 0, 1, 0);

        // Mid-BLINK reset with coincident game_over, then game_over+tick in IDLE
        drive(1, 0, 1, 0, 0);
        expect_all("go_winner0", 0, 1, 1, 0, 0);
        for (int k = 0; k < 25 + 20; k++) drive(1, 1, 0, 0, 0);
        expect_all("mid_blink", TGT, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        expect_all("reset_mid_blink", 0, 0, 0, 0, 0);
        chk("reset start_x", int'(start_x), XPOS);
        drive(1, 0, 0, 0, 0);
        expect_all("idle_after_reset", 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0);
        expect_all("go_with_tick", 0, 1, 1, 1, 0);
        drive(1, 0, 1, 0, 0);
        expect_all("go_in_slide", 0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0);
        expect_all("first_step", STEP, 1, 1, 1, 0);

        // Randomized run against the reference model
        drive(0, 0, 0, 0, 0);
        btn_r = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(7) == 0) btn_r = ~btn_r;
            rn_r = ($urandom_range(999) != 0);
            drive(rn_r, $urandom_range(1) == 1, $urandom_range(15) == 0,
                  $urandom_range(1) == 1, btn_r);
            expect_all($sformatf("rnd%0d", c), m_y, model_ten(), m_phase != 0, m_w, m_req);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
